// File: rtl/bcd_display_scheduler_pkg.sv
// Shared types and helpers for the BCD display scheduler: FSM state encoding
// and the sign-magnitude value normalisation applied to CPU writes.
package bcd_disp_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ADVANCE = 2'd1,
        SHOW    = 2'd2
    } state_t;

    localparam logic [5:0] NEG_ZERO = 6'b100000;

    // Negative zero would light a lone minus sign; store it as plain zero instead.
    function automatic logic [5:0] normalize_bcd(input logic [5:0] value);
        return (value == NEG_ZERO) ? 6'b000000 : value;
    endfunction

endpackage

// File: rtl/bcd_display_scheduler_if.sv
// CPU write port into the shadow slots: a plain valid/ready handshake carrying
// the target slot index and the 6-bit sign-magnitude value.
interface bcd_display_scheduler_if #(
    parameter int IDX_W = 2
);
    logic             wr_valid;
    logic [IDX_W-1:0] wr_idx;
    logic [5:0]       wr_data;
    logic             wr_ready;

    modport master (
        output wr_valid,
        output wr_idx,
        output wr_data,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_idx,
        input  wr_data,
        output wr_ready
    );
endinterface

// File: rtl/bcd_display_scheduler_rr_next_pick.sv
// Combinational round-robin picker: finds the first enabled slot starting at
// base (inclusive) or just after base (exclusive), wrapping around.
module rr_next_pick #(
    parameter int NUM_SRC = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_SRC-1:0] src_en,
    input  logic [IDX_W-1:0]   base,
    input  logic               inclusive,
    output logic [IDX_W-1:0]   next_idx,
    output logic               found
);

    localparam logic [IDX_W:0] N_SLOTS = (IDX_W+1)'(NUM_SRC);

    logic [NUM_SRC-1:0][IDX_W-1:0] cand;
    logic [NUM_SRC-1:0]            hit;

    // Candidate gi is the slot gi steps away from the search start; in exclusive
    // mode the last candidate lands back on base, so a lone enabled slot is kept.
    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_cand
            logic [IDX_W:0] sum;
            assign sum = {1'b0, base} + (IDX_W+1)'(gi) + {{IDX_W{1'b0}}, ~inclusive};
            assign cand[gi] = (sum >= N_SLOTS) ? IDX_W'(sum - N_SLOTS) : sum[IDX_W-1:0];
            assign hit[gi]  = src_en[cand[gi]];
        end
    endgenerate

    always_comb begin
        next_idx = '0;
        found    = 1'b0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (hit[i]) begin
                next_idx = cand[i];
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bcd_display_scheduler.sv
// Time-shares one sign-magnitude BCD/7-seg decoder among NUM_SRC CPU-written
// shadow slots, scanning the enabled slots round-robin for DWELL cycles each.
module bcd_display_scheduler
    import bcd_disp_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int IDX_W   = 2,
    parameter int DWELL_W = 16,
    parameter int DWELL   = 50000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    bcd_display_scheduler_if.slave  wr,
    input  logic [NUM_SRC-1:0]      src_en,
    input  logic                    hold,
    output logic [5:0]              bcd_out,
    output logic [IDX_W-1:0]        src_sel,
    output logic                    sel_valid
);

    localparam logic [DWELL_W-1:0] CNT_LAST = DWELL_W'(DWELL - 1);

    state_t               state_reg, state_next;
    logic [IDX_W-1:0]     cur_reg, cur_next;
    logic [DWELL_W-1:0]   cnt_reg, cnt_next;
    logic                 first_reg, first_next;

    logic [5:0]           bcd_out_reg, bcd_out_next;
    logic [IDX_W-1:0]     src_sel_reg, src_sel_next;
    logic                 sel_valid_reg, sel_valid_next;
    logic                 wr_ready_reg, wr_ready_next;

    logic [NUM_SRC-1:0][5:0] shadow_w;
    logic                    accept;

    logic [IDX_W-1:0]     pick_base;
    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_found;

    assign accept = wr.wr_valid & wr_ready_reg;

    // Shadow slots; indices beyond NUM_SRC match no slot, so such writes are
    // acknowledged and dropped.
    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_slot
            logic [5:0] slot_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    slot_reg <= '0;
                end else if (accept && (wr.wr_idx == IDX_W'(gi))) begin
                    slot_reg <= normalize_bcd(wr.wr_data);
                end
            end
            assign shadow_w[gi] = slot_reg;
        end
    endgenerate

    // The first pick after IDLE searches inclusively from slot 0; later picks
    // search exclusively after the slot just shown.
    assign pick_base = first_reg ? '0 : cur_reg;

    rr_next_pick #(
        .NUM_SRC (NUM_SRC),
        .IDX_W   (IDX_W)
    ) u_pick (
        .src_en    (src_en),
        .base      (pick_base),
        .inclusive (first_reg),
        .next_idx  (pick_idx),
        .found     (pick_found)
    );

    always_comb begin
        state_next = state_reg;
        cur_next   = cur_reg;
        cnt_next   = cnt_reg;
        first_next = first_reg;
        case (state_reg)
            IDLE: begin
                if (|src_en) begin
                    state_next = ADVANCE;
                    first_next = 1'b1;
                end
            end
            ADVANCE: begin
                first_next = 1'b0;
                if (pick_found) begin
                    state_next = SHOW;
                    cur_next   = pick_idx;
                    cnt_next   = '0;
                end else begin
                    state_next = IDLE;
                end
            end
            SHOW: begin
                // Losing the enable beats both hold and the dwell count.
                if (!src_en[cur_reg]) begin
                    state_next = ADVANCE;
                end else if (!hold) begin
                    if (cnt_reg == CNT_LAST) begin
                        state_next = ADVANCE;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with it;
    // during ADVANCE the previous slot stays on the display.
    always_comb begin
        bcd_out_next   = bcd_out_reg;
        src_sel_next   = src_sel_reg;
        sel_valid_next = sel_valid_reg;
        wr_ready_next  = (state_next != ADVANCE);
        case (state_next)
            IDLE: begin
                bcd_out_next   = '0;
                sel_valid_next = 1'b0;
            end
            SHOW: begin
                bcd_out_next   = shadow_w[cur_next];
                src_sel_next   = cur_next;
                sel_valid_next = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            cur_reg       <= '0;
            cnt_reg       <= '0;
            first_reg     <= 1'b0;
            bcd_out_reg   <= '0;
            src_sel_reg   <= '0;
            sel_valid_reg <= 1'b0;
            wr_ready_reg  <= 1'b1;
        end else begin
            state_reg     <= state_next;
            cur_reg       <= cur_next;
            cnt_reg       <= cnt_next;
            first_reg     <= first_next;
            bcd_out_reg   <= bcd_out_next;
            src_sel_reg   <= src_sel_next;
            sel_valid_reg <= sel_valid_next;
            wr_ready_reg  <= wr_ready_next;
        end
    end

    assign bcd_out     = bcd_out_reg;
    assign src_sel     = src_sel_reg;
    assign sel_valid   = sel_valid_reg;
    assign wr.wr_ready = wr_ready_reg;

endmodule

// File: tb/tb_bcd_display_scheduler.sv
// Self-checking bench for bcd_display_scheduler (NUM_SRC=4, DWELL=4): directed
// scenarios followed by random traffic, all compared against a behavioural model.
module tb_bcd_display_scheduler;

    localparam int NUM_SRC = 4;
    localparam int IDX_W   = 2;
    localparam int DWELL   = 4;

    localparam int P_IDLE = 0;
    localparam int P_SWITCH = 1;
    localparam int P_SHOW = 2;

    logic                clk;
    logic                rst_n;
    logic [NUM_SRC-1:0]  src_en;
    logic                hold;
    logic [5:0]          bcd_out;
    logic [IDX_W-1:0]    src_sel;
    logic                sel_valid;

    bcd_display_scheduler_if #(.IDX_W(IDX_W)) wif ();

    bcd_display_scheduler #(
        .NUM_SRC (NUM_SRC),
        .IDX_W   (IDX_W),
        .DWELL_W (16),
        .DWELL   (DWELL)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr        (wif),
        .src_en    (src_en),
        .hold      (hold),
        .bcd_out   (bcd_out),
        .src_sel   (src_sel),
        .sel_valid (sel_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model: what the display should be doing, in plain integers.
    int         m_phase;
    int         m_cur;
    int         m_age;
    bit         m_first;
    logic [5:0] m_shadow [NUM_SRC];
    logic [5:0] exp_bcd;
    int         exp_sel;
    bit         exp_valid;
    bit         exp_ready;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = P_IDLE;
        m_cur   = 0;
        m_age   = 0;
        m_first = 0;
        for (int i = 0; i < NUM_SRC; i++) m_shadow[i] = 6'd0;
        exp_bcd   = 6'd0;
        exp_sel   = 0;
        exp_valid = 0;
        exp_ready = 1;
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        int  nphase = m_phase;
        int  ncur   = m_cur;
        int  nage   = m_age;
        bit  nfirst = m_first;
        bit  found  = 0;
        bit  acc    = wif.wr_valid && exp_ready;
        case (m_phase)
            P_IDLE: if (src_en != 0) begin nphase = P_SWITCH; nfirst = 1; end
            P_SWITCH: begin
                for (int k = 0; k < NUM_SRC; k++) begin
                    int s = m_first ? k : (m_cur + 1 + k) % NUM_SRC;
                    if (!found && src_en[s]) begin found = 1; ncur = s; end
                end
                nfirst = 0;
                if (found) begin nphase = P_SHOW; nage = 0; end
                else nphase = P_IDLE;
            end
            default: begin
                if (!src_en[m_cur]) nphase = P_SWITCH;
                else if (!hold) begin
                    if (m_age == DWELL - 1) nphase = P_SWITCH;
                    else nage = m_age + 1;
                end
            end
        endcase
        if (nphase == P_IDLE) begin
            exp_bcd = 6'd0; exp_valid = 0;
        end else if (nphase == P_SHOW) begin
            exp_bcd = m_shadow[ncur]; exp_sel = ncur; exp_valid = 1;
        end
        exp_ready = (nphase != P_SWITCH);
        if (acc && int'(wif.wr_idx) < NUM_SRC)
            m_shadow[wif.wr_idx] = (wif.wr_data == 6'b100000) ? 6'd0 : wif.wr_data;
        m_phase = nphase; m_cur = ncur; m_age = nage; m_first = nfirst;
    endtask

    task automatic check_all();
        chk("bcd_out",   int'(bcd_out),      int'(exp_bcd));
        chk("src_sel",   int'(src_sel),      exp_sel);
        chk("sel_valid", int'(sel_valid),    int'(exp_valid));
        chk("wr_ready",  int'(wif.wr_ready), int'(exp_ready));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic write_slot(input int idx, input logic [5:0] data);
        bit done = 0;
        wif.wr_valid = 1'b1;
        wif.wr_idx   = IDX_W'(idx);
        wif.wr_data  = data;
        for (int n = 0; n < 6 && !done; n++) begin
            done = exp_ready;
            tick();
        end
        wif.wr_valid = 1'b0;
        checks++;
        assert (done) else begin
            errors++;
            $error("FAIL write_accept: slot %0d not accepted within 6 cycles", idx);
        end
    endtask

    task automatic wait_show(input int want_cur, input int want_age);
        bit ok = 0;
        for (int n = 0; n < 40 && !ok; n++) begin
            tick();
            ok = (m_phase == P_SHOW) && (m_age == want_age) && (want_cur < 0 || m_cur == want_cur);
        end
        checks++;
        assert (ok) else begin
            errors++;
            $error("FAIL wait_show: slot %0d age %0d not reached within 40 cycles", want_cur, want_age);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int other;
        logic [5:0] cur_val;
        rst_n        = 1'b0;
        src_en       = '0;
        hold         = 1'b0;
        wif.wr_valid = 1'b0;
        wif.wr_idx   = '0;
        wif.wr_data  = '0;
        model_reset();
        #12;
        chk("reset_bcd_out", int'(bcd_out), 0);
        chk("reset_sel_valid", int'(sel_valid), 0);
        chk("reset_wr_ready", int'(wif.wr_ready), 1);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // 1: idle with nothing enabled
        repeat (20) tick();
        chk("idle_bcd_out", int'(bcd_out), 0);
        chk("idle_sel_valid", int'(sel_valid), 0);

        // 2: two-slot scan, slot 0 shown first
        write_slot(0, 6'd5);
        write_slot(2, 6'b100011);
        src_en = 4'b0101;
        tick(); tick();
        chk("scan_first_sel", int'(src_sel), 0);
        chk("scan_first_bcd", int'(bcd_out), 5);
        repeat (25) tick();

        // 3: negative zero normalised, single-slot loop
        write_slot(1, 6'd9);
        write_slot(1, 6'b100000);
        src_en = 4'b0010;
        repeat (15) tick();
        chk("negzero_bcd", int'(bcd_out), 0);
        chk("negzero_sel", int'(src_sel), 1);
        chk("negzero_valid", int'(sel_valid), 1);

        // 4: hold at cnt=1 on slot 0
        src_en = 4'b0001;
        wait_show(0, 1);
        hold = 1'b1;
        for (int n = 0; n < 10; n++) begin
            tick();
            chk("hold_sel", int'(src_sel), 0);
        end
        hold = 1'b0;
        tick(); chk("release_ready_1", int'(wif.wr_ready), 1);
        tick(); chk("release_ready_2", int'(wif.wr_ready), 1);
        tick(); chk("release_advance", int'(wif.wr_ready), 0);

        // 5: drop the current slot's enable mid-show, then disable all
        src_en = 4'b0101;
        wait_show(-1, 1);
        other = (m_cur == 0) ? 2 : 0;
        src_en = (m_cur == 0) ? 4'b0100 : 4'b0001;
        tick(); chk("drop_advance", int'(wif.wr_ready), 0);
        tick(); chk("drop_next_sel", int'(src_sel), other);
        src_en = 4'b0000;
        tick(); tick();
        chk("drop_idle_valid", int'(sel_valid), 0);

        // 6: write during ADVANCE waits a cycle; write to shown slot
        src_en = 4'b0011;
        for (int n = 0; n < 20 && exp_ready; n++) tick();
        chk("adv_ready_low", int'(wif.wr_ready), 0);
        wif.wr_valid = 1'b1; wif.wr_idx = 2'd3; wif.wr_data = 6'd21;
        tick();
        chk("adv_ready_back", int'(wif.wr_ready), 1);
        tick();
        wif.wr_valid = 1'b0;
        wait_show(-1, 1);
        cur_val = bcd_out;
        write_slot(m_cur, 6'd17);
        chk("wr_cur_same_cycle", int'(bcd_out), int'(cur_val));
        tick();
        chk("wr_cur_visible", int'(bcd_out), 17);

        // random traffic
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 9) == 0) src_en = NUM_SRC'($urandom_range(0, 15));
            hold         = ($urandom_range(0, 4) == 0);
            wif.wr_valid = ($urandom_range(0, 2) == 0);
            wif.wr_idx   = IDX_W'($urandom_range(0, NUM_SRC - 1));
            wif.wr_data  = ($urandom_range(0, 5) == 0) ? 6'b100000 : 6'($urandom);
            tick();
        end
        wif.wr_valid = 1'b0;
        hold = 1'b0;

        // async reset mid-show
        src_en = 4'b0110;
        wait_show(-1, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_bcd_out", int'(bcd_out), 0);
        chk("arst_src_sel", int'(src_sel), 0);
        chk("arst_sel_valid", int'(sel_valid), 0);
        chk("arst_wr_ready", int'(wif.wr_ready), 1);
        model_reset();
        src_en = 4'b0000;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (5) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
